keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, debounces it and presents one stable key code to the access/weighing control state machine that sits directly downstream. It drives the keypad columns and samples the rows. It converts a clean single-key press into a 5-bit code on `num`, which holds until the next accepted press. `key_pulse` marks each accepted press for one cycle.

---
 rtl/keypad_pkg.sv | 56 +++++
 rtl/keypad_col_scan.sv | 90 +++++++++
 rtl/keypad_scanner.sv | 109 ++++++++++
 tb/tb_keypad_scanner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: key codes, debounce
// states, per-frame scan result and the row/column to key-code lookup.
package keypad_pkg;

    localparam logic [4:0] KEY_0    = 5'h00;
    localparam logic [4:0] KEY_1    = 5'h01;
    localparam logic [4:0] KEY_2    = 5'h02;
    localparam logic [4:0] KEY_3    = 5'h03;
    localparam logic [4:0] KEY_4    = 5'h04;
    localparam logic [4:0] KEY_5    = 5'h05;
    localparam logic [4:0] KEY_6    = 5'h06;
    localparam logic [4:0] KEY_7    = 5'h07;
    localparam logic [4:0] KEY_8    = 5'h08;
    localparam logic [4:0] KEY_9    = 5'h09;
    localparam logic [4:0] KEY_A    = 5'h0A;
    localparam logic [4:0] KEY_B    = 5'h0B;
    localparam logic [4:0] KEY_C    = 5'h0C;
    localparam logic [4:0] KEY_D    = 5'h0D;
    localparam logic [4:0] KEY_STAR = 5'h0E;
    localparam logic [4:0] KEY_HASH = 5'h0F;
    localparam logic [4:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD} db_state_t;

    typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_kind_t;

    typedef struct packed {
        frame_kind_t kind;
        logic [4:0]  code;
    } frame_result_t;

    function automatic logic [4:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        code = KEY_NONE;
        case ({r, c})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            4'hF: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column driver and row sampler: synchronizes the rows, rotates the one-hot-low
// column every SCAN_DIV cycles and assembles one result per 4-slot frame.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    row,
    output logic [3:0]    col,
    output logic          frame_end,
    output frame_result_t frame_result
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [3:0]    row_meta, row_sync;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic          hit_q, multi_q, hit_n, multi_n;
    logic [4:0]    code_q, code_n;
    logic [3:0]    low;
    logic [2:0]    low_cnt;
    logic [1:0]    low_row;
    logic          slot_end;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    // Merge this slot's sample into the frame so far; on the frame-end cycle
    // the merged value is the frame result itself.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        low     = ~row_sync;
        low_cnt = '0;
        low_row = '0;
        hit_n   = hit_q;
        multi_n = multi_q;
        code_n  = code_q;
        for (int r = 0; r < 4; r++) begin
            if (low[r]) begin
                low_cnt = low_cnt + 3'd1;
                low_row = 2'(r);
            end
        end
        if (low_cnt > 3'd1 || (low_cnt == 3'd1 && hit_q)) begin
            multi_n = 1'b1;
        end else if (low_cnt == 3'd1) begin
            hit_n  = 1'b1;
            code_n = key_lookup(low_row, col_idx);
        end
        frame_result.kind = multi_n ? FR_MULTI : (hit_n ? FR_KEY : FR_NONE);
        frame_result.code = (hit_n && !multi_n) ? code_n : KEY_NONE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            slot_cnt <= '0;
            col_idx  <= '0;
            hit_q    <= 1'b0;
            multi_q  <= 1'b0;
            code_q   <= KEY_NONE;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (slot_end) begin
                slot_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                if (frame_end) begin
                    hit_q   <= 1'b0;
                    multi_q <= 1'b0;
                    code_q  <= KEY_NONE;
                end else begin
                    hit_q   <= hit_n;
                    multi_q <= multi_n;
                    code_q  <= code_n;
                end
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with frame-based debounce. Optional macro
// KEYPAD_RELEASE_CLEAR_EN returns num to KEY_NONE when a held key is released.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] num,
    output logic       key_pulse
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DF_C = CW'(DEBOUNCE_FRAMES);

    frame_result_t fr;
    logic          frame_end;
    db_state_t     state_q, state_n;
    logic [4:0]    cand_q, cand_n, num_n;
    logic [CW-1:0] press_q, press_n, rel_q, rel_n;
    logic          pulse_n;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .row          (row),
        .col          (col),
        .frame_end    (frame_end),
        .frame_result (fr)
    );

    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        press_n = press_q;
        rel_n   = rel_q;
        num_n   = num;
        pulse_n = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (fr.kind == FR_KEY) begin
                        state_n = PRESS_WAIT;
                        cand_n  = fr.code;
                        press_n = CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (fr.kind != FR_KEY) begin
                        state_n = IDLE;
                        press_n = '0;
                    end else if (fr.code != cand_q) begin
                        cand_n  = fr.code;
                        press_n = CW'(1);
                    end else if (press_q != DF_C) begin
                        press_n = press_q + CW'(1);
                    end
                end
                HELD: begin
                    if (fr.kind != FR_NONE) begin
                        rel_n = '0;
                    end else if (rel_q != DF_C) begin
                        rel_n = rel_q + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase

            // Checked on the next-state values so DEBOUNCE_FRAMES=1 goes IDLE->HELD in one frame.
            if (state_n == PRESS_WAIT && press_n == DF_C) begin
                state_n = HELD;
                num_n   = cand_n;
                pulse_n = 1'b1;
                press_n = '0;
                rel_n   = '0;
            end
            if (state_q == HELD && rel_n == DF_C) begin
                state_n = IDLE;
                rel_n   = '0;
`ifdef KEYPAD_RELEASE_CLEAR_EN
                num_n   = KEY_NONE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cand_q    <= KEY_NONE;
            press_q   <= '0;
            rel_q     <= '0;
            num       <= KEY_NONE;
            key_pulse <= 1'b0;
        end else begin
            state_q   <= state_n;
            cand_q    <= cand_n;
            press_q   <= press_n;
            rel_q     <= rel_n;
            num       <= num_n;
            key_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from col and a
// pressed-key mask; vectors are applied one frame at a time, aligned to reset.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int NVEC     = 36;

    localparam logic [15:0] K0  = 16'h0000;
    localparam logic [15:0] K5  = 16'h0020;   // r1 c1
    localparam logic [15:0] KA  = 16'h0008;   // r0 c3
    localparam logic [15:0] KB  = 16'h0080;   // r1 c3
    localparam logic [15:0] K19 = 16'h0401;   // r0 c0 + r2 c2

    typedef struct {
        logic [15:0] mask;
        logic        pulse;
        logic [4:0]  num;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col;
    logic [4:0]  num;
    logic        key_pulse;
    logic [15:0] pressed = '0;
    logic [3:0]  exp_col;
    vec_t        vecs [NVEC];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .num       (num),
        .key_pulse (key_pulse)
    );

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    always @(negedge clk) begin
        if (rst_n && key_pulse === 1'b1) pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] rc(input logic [4:0] v);
`ifdef KEYPAD_RELEASE_CLEAR_EN
        return KEY_NONE;
`else
        return v;
`endif
    endfunction

    task automatic set_vec(input int i, input logic [15:0] m, input logic p, input logic [4:0] n);
        vecs[i].mask  = m;
        vecs[i].pulse = p;
        vecs[i].num   = n;
    endtask

    task automatic run_frame(input logic [15:0] m);
        pressed = m;
        repeat (FRAME) @(posedge clk);
        #1;
    endtask

    initial begin
        set_vec(0,  K0,  0, KEY_NONE);
        set_vec(1,  K5,  0, KEY_NONE);
        set_vec(2,  K5,  0, KEY_NONE);
        set_vec(3,  K5,  1, KEY_5);
        set_vec(4,  K5,  0, KEY_5);
        set_vec(5,  K5,  0, KEY_5);
        set_vec(6,  K0,  0, KEY_5);
        set_vec(7,  K0,  0, KEY_5);
        set_vec(8,  K0,  0, rc(KEY_5));
        set_vec(9,  KA,  0, rc(KEY_5));
        set_vec(10, K0,  0, rc(KEY_5));
        set_vec(11, KA,  0, rc(KEY_5));
        set_vec(12, KA,  0, rc(KEY_5));
        set_vec(13, KA,  1, KEY_A);
        set_vec(14, KA,  0, KEY_A);
        set_vec(15, K0,  0, KEY_A);
        set_vec(16, K0,  0, KEY_A);
        set_vec(17, K0,  0, rc(KEY_A));
        set_vec(18, K19, 0, rc(KEY_A));
        set_vec(19, K19, 0, rc(KEY_A));
        set_vec(20, KB,  0, rc(KEY_A));
        set_vec(21, KB,  0, rc(KEY_A));
        set_vec(22, KB,  1, KEY_B);
        set_vec(23, K0,  0, KEY_B);
        set_vec(24, K0,  0, KEY_B);
        set_vec(25, K0,  0, rc(KEY_B));
        set_vec(26, KB,  0, rc(KEY_B));
        set_vec(27, KB,  0, rc(KEY_B));
        set_vec(28, KB,  1, KEY_B);
        set_vec(29, KB,  0, KEY_B);
        set_vec(30, K0,  0, KEY_B);
        set_vec(31, K0,  0, KEY_B);
        set_vec(32, K19, 0, KEY_B);
        set_vec(33, K0,  0, KEY_B);
        set_vec(34, K0,  0, KEY_B);
        set_vec(35, K0,  0, rc(KEY_B));

        repeat (3) @(posedge clk);
        #1;
        check("reset num", 32'(num), 32'(KEY_NONE));
        check("reset col", 32'(col), 32'(4'b1110));
        check("reset key_pulse", 32'(key_pulse), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
            check($sformatf("col rotate %0d", i), 32'(col), 32'(exp_col));
        end
        check("idle frame key_pulse", 32'(key_pulse), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_frame(vecs[i].mask);
            check($sformatf("vec%0d key_pulse", i), 32'(key_pulse), 32'(vecs[i].pulse));
            check($sformatf("vec%0d num", i), 32'(num), 32'(vecs[i].num));
        end

        // Reset in the middle of PRESS_WAIT must discard the partial debounce.
        run_frame(K5);
        run_frame(K5);
        check("pre-reset key_pulse", 32'(key_pulse), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid reset num", 32'(num), 32'(KEY_NONE));
        check("mid reset col", 32'(col), 32'(4'b1110));
        check("mid reset key_pulse", 32'(key_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(K5);
        check("post-reset f1 key_pulse", 32'(key_pulse), 32'd0);
        run_frame(K5);
        check("post-reset f2 key_pulse", 32'(key_pulse), 32'd0);
        run_frame(K5);
        check("post-reset f3 key_pulse", 32'(key_pulse), 32'd1);
        check("post-reset f3 num", 32'(num), 32'(KEY_5));
        run_frame(K0);
        check("post-reset held num", 32'(num), 32'(KEY_5));

        check("total key_pulse cycles", 32'(pulses), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
